// File: rtl/op_sequencer.sv
// op_sequencer: queues operation commands and steps reg-file reads, ALU run, writeback.
// Ports: cmd_* push side, reg_sel/assign_op* read, alu_* ALU, wr_* writeback, busy/done/err status.
module op_sequencer #(
  parameter int REG_W   = 3,
  parameter int OP_W    = 3,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [REG_W-1:0] cmd_src1,
  input  logic [REG_W-1:0] cmd_src2,
  input  logic [REG_W-1:0] cmd_dst,
  input  logic [OP_W-1:0]  cmd_op,
  output logic [REG_W-1:0] reg_sel,
  output logic             assign_op1,
  output logic             assign_op2,
  output logic             alu_en,
  output logic [OP_W-1:0]  alu_op,
  input  logic             alu_done,
  output logic             wr_en,
  output logic [REG_W-1:0] wr_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [REG_W-1:0] dst;
    logic [OP_W-1:0]  op;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_RD2, S_EXEC, S_WAIT, S_WB, S_ERR
  } state_t;

  cmd_t            mem_q [DEPTH];
  logic [AW:0]     wp_q, rp_q;
  logic            empty, full, push, pop;
  cmd_t            head, cmd_in;
  logic            bad;

  state_t          state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  logic [1:0]      code_q, code_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Extra pointer MSB separates full from empty when indices match.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);

  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign cmd_in    = '{cmd_src1, cmd_src2, cmd_dst, cmd_op};
  assign head      = mem_q[rp_q[AW-1:0]];

  assign bad = (head.src1 == '0) || (head.src2 == '0) ||
               (head.dst == '0)  || (head.op == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q[AW-1:0]] <= cmd_in;
        wp_q <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          cmd_d = head;
          if (bad) begin
            state_d = S_ERR;
            code_d  = 2'b01;
          end else begin
            state_d = S_RD1;
          end
        end
      end
      S_RD1:  state_d = S_RD2;
      S_RD2:  state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (alu_done) begin
          state_d = S_WB;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
          code_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reg_sel    = '0;
    assign_op1 = 1'b0;
    assign_op2 = 1'b0;
    alu_en     = 1'b0;
    alu_op     = '0;
    wr_en      = 1'b0;
    wr_sel     = '0;
    done       = 1'b0;
    err        = 1'b0;
    err_code   = 2'b00;
    unique case (state_q)
      S_RD1: begin
        reg_sel    = cmd_q.src1;
        assign_op1 = 1'b1;
      end
      S_RD2: begin
        reg_sel    = cmd_q.src2;
        assign_op2 = 1'b1;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        alu_op = cmd_q.op;
      end
      S_WAIT: alu_op = cmd_q.op;
      S_WB: begin
        wr_en  = 1'b1;
        wr_sel = cmd_q.dst;
        done   = 1'b1;
      end
      S_ERR: begin
        err      = 1'b1;
        err_code = code_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: directed and random stimulus for op_sequencer,
// checked each cycle against a job-age reference model.
module tb_op_sequencer;

  localparam int RW      = 3;
  localparam int OW      = 3;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [RW-1:0] cmd_src1 = '0, cmd_src2 = '0, cmd_dst = '0;
  logic [OW-1:0] cmd_op = '0;
  logic [RW-1:0] reg_sel;
  logic          assign_op1, assign_op2, alu_en;
  logic [OW-1:0] alu_op;
  logic          alu_done = 1'b0;
  logic          wr_en;
  logic [RW-1:0] wr_sel;
  logic          busy, done, err;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  op_sequencer #(
    .REG_W(RW), .OP_W(OW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
    .cmd_dst(cmd_dst), .cmd_op(cmd_op),
    .reg_sel(reg_sel), .assign_op1(assign_op1),
    .assign_op2(assign_op2), .alu_en(alu_en),
    .alu_op(alu_op), .alu_done(alu_done),
    .wr_en(wr_en), .wr_sel(wr_sel), .busy(busy),
    .done(done), .err(err), .err_code(err_code)
  );

  typedef struct {
    int s1;
    int s2;
    int d;
    int op;
  } cmd_t;

  // Model: queued commands plus one job aged in cycles since its pop.
  // age 1..3 = operand reads and ALU start, age >= 4 = waiting on ALU;
  // outc: 0 running, 1 writeback cycle, 2 abort cycle.
  cmd_t q[$];
  cmd_t cur;
  bit   act;
  int   age, outc, code;
  int   n_chk, n_fail;
  int   dmode;

  logic [18:0] obs;
  assign obs = {cmd_ready, reg_sel, assign_op1, assign_op2,
                alu_en, alu_op, wr_en, wr_sel, busy, done,
                err, err_code};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic cmd_t mk(int s1, int s2, int d, int op);
    cmd_t c;
    c.s1 = s1; c.s2 = s2; c.d = d; c.op = op;
    return c;
  endfunction

  // 0 idle, 1 read1, 2 read2, 3 start, 4 wait, 5 writeback, 6 abort
  function automatic int phase();
    if (!act)      return 0;
    if (outc == 1) return 5;
    if (outc == 2) return 6;
    if (age <= 3)  return age;
    return 4;
  endfunction

  function automatic logic [18:0] exp_out();
    int ph;
    logic [RW-1:0] rs, ws;
    logic [OW-1:0] op;
    logic [1:0] ec;
    ph = phase();
    rs = (ph == 1) ? RW'(cur.s1) : (ph == 2) ? RW'(cur.s2) : '0;
    op = (ph == 3 || ph == 4) ? OW'(cur.op) : '0;
    ws = (ph == 5) ? RW'(cur.d) : '0;
    ec = (ph == 6) ? 2'(code) : 2'b00;
    return {q.size() < DEPTH, rs, ph == 1, ph == 2,
            ph == 3, op, ph == 5, ws,
            act || q.size() > 0, ph == 5, ph == 6, ec};
  endfunction

  task automatic cycle(input bit v, input cmd_t c);
    bit rdy, dn;
    int ph;
    @(negedge clk);
    chk("outs", 32'(obs), 32'(exp_out()));
    ph = phase();
    case (dmode)
      0:       dn = 1'b0;
      1:       dn = 1'b1;
      2:       dn = (ph == 3);
      default: dn = ($urandom % 4 == 0);
    endcase
    cmd_valid = v;
    cmd_src1  = RW'(c.s1);
    cmd_src2  = RW'(c.s2);
    cmd_dst   = RW'(c.d);
    cmd_op    = OW'(c.op);
    alu_done  = dn;
    rdy = q.size() < DEPTH;
    if (!act) begin
      if (q.size() > 0) begin
        cur = q.pop_front();
        act = 1;
        age = 1;
        if (cur.s1 == 0 || cur.s2 == 0 || cur.d == 0 || cur.op == 0) begin
          outc = 2;
          code = 1;
        end else begin
          outc = 0;
        end
      end
    end else if (outc != 0) begin
      act  = 0;
      outc = 0;
    end else begin
      if (age >= 4) begin
        if (dn) begin
          outc = 1;
        end else if (age == 3 + TIMEOUT) begin
          outc = 2;
          code = 2;
        end
      end
      age++;
    end
    if (v && rdy) q.push_back(c);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, mk(0, 0, 0, 0));
  endtask

  task automatic push(input cmd_t c);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      bit r;
      r = q.size() < DEPTH;
      cycle(1'b1, c);
      ok = r;
    end
    chk("push_ok", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst      = 1'b0;
    cmd_valid = 1'b0;
    alu_done  = 1'b0;
    cmd_src1  = '0;
    cmd_src2  = '0;
    cmd_dst   = '0;
    cmd_op    = '0;
    q.delete();
    act  = 0;
    outc = 0;
    age  = 0;
    #1;
    chk("rst", 32'(obs), 32'(exp_out()));
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    dmode  = 1;
    do_reset();

    push(mk(1, 2, 3, 4));
    idle(8);

    push(mk(1, 2, 5, 3));
    push(mk(3, 4, 6, 2));
    push(mk(7, 7, 1, 1));
    idle(30);

    push(mk(1, 2, 3, 0));
    push(mk(1, 2, 0, 5));
    push(mk(2, 2, 5, 1));
    idle(20);

    dmode = 0;
    push(mk(1, 2, 3, 4));
    idle(TIMEOUT + 10);

    dmode = 2;
    push(mk(4, 5, 6, 7));
    idle(TIMEOUT + 10);

    dmode = 0;
    push(mk(1, 2, 3, 4));
    push(mk(2, 3, 4, 5));
    for (int i = 0; i < 50 && phase() != 4; i++) idle(1);
    chk("wait_reach", 32'(phase()), 32'd4);
    idle(1);
    do_reset();
    idle(TIMEOUT + 10);

    dmode = 3;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom % 3 == 0,
            mk($urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7)));
      if (i % 997 == 996) do_reset();
    end
    idle(TIMEOUT + 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
